mem_arbiter: RTL
================

# mem_arbiter

Two-requester memory arbiter that sits between the RV64 core's instruction-fetch path and its load/store path and a single shared memory port. It accepts one request at a time from either side, uses round-robin priority when both request together, drives the request onto the memory port with a valid/ready handshake, and returns the memory response to the requester that issued it. At most one transaction is in flight.

## Interface
Parameters:
- `ADDR_W`, default 64: address width.
- `DATA_W`, default 64: memory data width; `DATA_W/8` byte-mask bits.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `if_req_valid` in 1: fetch request; held until accepted.
- `if_req_ready` out 1: fetch request accepted this cycle.
- `if_addr` in ADDR_W: fetch byte address.
- `if_resp_valid` out 1: one-cycle pulse; `if_rdata` valid.
- `if_rdata` out 32: fetched instruction word.
- `ls_req_valid` in 1: load/store request; held until accepted.
- `ls_req_ready` out 1: load/store request accepted this cycle.
- `ls_addr` in ADDR_W: load/store byte address.
- `ls_wen` in 1: 1 = store, 0 = load.
- `ls_wdata` in DATA_W: store data.
- `ls_wmask` in DATA_W/8: store byte enables.
- `ls_resp_valid` out 1: one-cycle pulse; load data or store acknowledge.
- `ls_rdata` out DATA_W: load data; 0 for stores.
- `mem_req_valid` out 1: request to memory.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_addr` out ADDR_W: doubleword-aligned address.
- `mem_wen`, `mem_wdata`, `mem_wmask` out 1 / DATA_W / DATA_W/8: write controls.
- `mem_resp_valid` in 1: memory response. Memory returns one response for every request, read or write.
- `mem_rdata` in DATA_W: read data.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - If neither requester is valid, stay in IDLE.
  - If exactly one is valid, grant it.
  - If both are valid, grant the side opposite `last_grant`.
  - Assert the granted side's `*_req_ready` combinationally; at most one ready is high at a time.
  - Latch the granted side's address, wen, wdata and wmask, plus the grant identity. Fetch requests latch `wen`=0 and `wmask`=0.
  - Update `last_grant` and go to REQ.
- REQ:
  - `mem_req_valid`=1 and the latched fields drive the memory port.
  - `mem_addr` = {addr[ADDR_W-1:3], 3'b000}.
  - When `mem_req_ready`=1, go to WAIT.
  - `mem_resp_valid` is ignored in this state.
- WAIT:
  - When `mem_resp_valid`=1, register the response data and go to RESP.
  - Both `*_req_ready` stay 0 until the state returns to IDLE.
- RESP:
  - Pulse `resp_valid` for one cycle to the granted side only, then go to IDLE.
  - `if_rdata` = latched addr[2] ? rdata[63:32] : rdata[31:0].
  - `ls_rdata` = full rdata for loads, 0 for stores.
- `last_grant` resets to LS, so the fetch side wins the first contention.
- Misaligned addresses are not flagged. Alignment and subword extraction beyond the 32-bit fetch select belong to the requester.

## Timing
- Reset values:
  - State IDLE, `last_grant`=LS.
  - All `*_req_ready`, `*_resp_valid`, `mem_req_valid`, `mem_wen` = 0.
  - `mem_addr`, `mem_wdata`, `mem_wmask`, `if_rdata`, `ls_rdata` = 0.
- Reset asserted mid-transaction: the transaction is abandoned with no response pulse. The memory side must tolerate a dropped request.
- Minimum latency, with `mem_req_ready` and `mem_resp_valid` both high as soon as they are sampled:
  - Accept in cycle 0.
  - `mem_req_valid` in cycle 1.
  - WAIT in cycle 2, response sampled.
  - `*_resp_valid` in cycle 3.
  - Next accept in cycle 4, i.e. one transaction per 4 cycles at best.
- `mem_req_valid` and the memory fields are registered and stay stable until `mem_req_ready` is seen.
- A requester that deasserts valid before ready simply loses its slot; nothing is latched.

## Test plan
- Single fetch: `if_addr`=0x80000004, memory returns rdata=0x00100073_00000013 one cycle after the request is accepted -> `if_rdata`=0x00100073 with one `if_resp_valid` pulse 3 cycles after `if_req_ready`; `mem_addr`=0x80000000.
- Store: `ls_addr`=0x80001008, `ls_wen`=1, `ls_wdata`=0xDEADBEEF, `ls_wmask`=0xFF -> memory port shows wen=1 with the same data and mask; `ls_resp_valid` pulses; `ls_rdata`=0.
- Contention: both sides valid continuously from reset -> grants alternate IF, LS, IF, LS; never two readies in one cycle.
- Backpressure: `mem_req_ready` held low for 5 cycles -> `mem_req_valid` and fields stay constant; no `*_req_ready` asserted; response delivered after ready.
- Spurious response: `mem_resp_valid` pulsed during REQ -> ignored; only the WAIT-state response produces a resp pulse.
- Reset in WAIT: `rst` low for 1 cycle -> all outputs 0 immediately; no `resp_valid`; next contention grants IF first.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between fetch and load/store
module mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_resp_valid,
    output logic [31:0]           if_rdata,
    input  logic                  ls_req_valid,
    output logic                  ls_req_ready,
    input  logic [ADDR_W-1:0]     ls_addr,
    input  logic                  ls_wen,
    input  logic [DATA_W-1:0]     ls_wdata,
    input  logic [DATA_W/8-1:0]   ls_wmask,
    output logic                  ls_resp_valid,
    output logic [DATA_W-1:0]     ls_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_wen,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_W-1:0]     mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(7);

    state_t                state, state_nxt;
    logic                  last_ls;
    logic                  gnt_ls_q;
    logic [ADDR_W-1:0]     addr_q;
    logic                  wen_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wmask_q;
    logic [DATA_W-1:0]     rdata_q;
    logic                  grant_if, grant_ls;

    // Fetch wins a tie unless it was the most recent grant.
    always_comb begin
        grant_if  = 1'b0;
        grant_ls  = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rst) begin
                    if (if_req_valid && (!ls_req_valid || last_ls))
                        grant_if = 1'b1;
                    else if (ls_req_valid)
                        grant_ls = 1'b1;
                end
                if (grant_if || grant_ls)
                    state_nxt = REQ;
            end
            REQ:     if (mem_req_ready) state_nxt = WAIT;
            WAIT:    if (mem_resp_valid) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            last_ls  <= 1'b1;
            gnt_ls_q <= 1'b0;
            addr_q   <= '0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state <= state_nxt;
            if (grant_if || grant_ls) begin
                last_ls  <= grant_ls;
                gnt_ls_q <= grant_ls;
                addr_q   <= grant_ls ? ls_addr : if_addr;
                wen_q    <= grant_ls & ls_wen;
                wdata_q  <= grant_ls ? ls_wdata : '0;
                wmask_q  <= grant_ls ? ls_wmask : '0;
            end
            if (state == WAIT && mem_resp_valid)
                rdata_q <= mem_rdata;
        end
    end

    assign if_req_ready  = grant_if;
    assign ls_req_ready  = grant_ls;
    assign mem_req_valid = (state == REQ);
    assign mem_addr      = addr_q & ~ALIGN_MASK;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;
    assign if_resp_valid = (state == RESP) && !gnt_ls_q;
    assign ls_resp_valid = (state == RESP) && gnt_ls_q;
    assign if_rdata      = addr_q[2] ? rdata_q[63:32] : rdata_q[31:0];
    assign ls_rdata      = wen_q ? '0 : rdata_q;

endmodule
